mac_result_requant: RTL and testbench
=====================================

// Module: mac_result_requant
// PURPOSE
//  Downstream stage of the vector MAC. Captures each accumulated dot-product result on the MAC's
//  one-cycle done pulse. Applies bias add, rounding arithmetic right shift and saturation to OUT_W.
//  Buffers the quantised values in a small FIFO drained by the writeback path over a valid/ready
//  handshake. The MAC has no backpressure, so this block never stalls its input and flags drops.
// PARAMETERS
//  ACC_W       32  width of signed MAC result and bias (2*WIDTH of the MAC)
//  OUT_W        8  width of signed quantised output
//  FIFO_DEPTH   4  output FIFO entries, power of two, >=2
//  SHIFT_W      5  width of shift amount, $clog2(ACC_W)
// PORTS
//  clk          in   1          clock, all state on rising edge
//  rst          in   1          asynchronous active-low reset
//  mac_result   in   ACC_W      signed accumulated result, valid when mac_done=1
//  mac_done     in   1          one-cycle pulse, result present same cycle
//  bias         in   ACC_W      signed bias, sampled with mac_done
//  shift        in   SHIFT_W    right-shift amount 0..ACC_W-1, sampled with mac_done
//  flush        in   1          synchronous clear of pipeline, FIFO and overflow flag
//  out_data     out  OUT_W      signed quantised value, FIFO head
//  out_valid    out  1          FIFO non-empty
//  out_ready    in   1          consumer accepts head when out_valid&out_ready
//  fifo_count   out  clog2(D)+1 current FIFO occupancy
//  overflow     out  1          sticky: a result was dropped because FIFO was full
// BEHAVIOUR
//  Reset (rst=0, async): pipeline valids=0, FIFO pointers/count=0, out_valid=0, out_data=0,
//   overflow=0; any in-flight results are discarded.
//  S1 (edge after mac_done cycle T): sum = sext(mac_result)+sext(bias), ACC_W+1 bits, no wrap;
//   shift registered alongside.
//  S2 (edge after T+1): if shift>0, sum += 1<<(shift-1) (round half up), then arithmetic >>shift;
//   saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  FIFO write on edge after T+2; out_valid first high in cycle T+3 when FIFO was empty (latency 3).
//  mac_done is accepted every cycle back-to-back; the pipeline never stalls.
//  Write with FIFO full and no pop this cycle: result dropped, overflow<=1 until flush/reset.
//  Write and pop in the same cycle with FIFO full: both happen, count unchanged, no overflow.
//  Pop on empty: ignored. out_data holds the head entry; it is stable while out_valid&!out_ready.
//  Pointers wrap modulo FIFO_DEPTH; count tracks occupancy 0..FIFO_DEPTH.
//  flush: on next edge clears S1/S2 valids, FIFO, overflow. A mac_done in the flush cycle is
//   discarded. Flush beats a simultaneous write or pop.
// CONFIGURATION
//  REQUANT_RELU_EN defined: after saturation, negative values are forced to 0
//   (output range [0, 2^(OUT_W-1)-1]).
//  Not defined: signed saturated value is passed unchanged.
// STRUCTURE
//  vec_mac_pkg: ACC_W/OUT_W localparams, acc_t and qout_t typedefs, sat_to_out() function.
//  Sub-module requant_fifo: synchronous FIFO, parameterised width/depth, with push/pop/full/
//   empty/count and flush.
//  Datapath S1/S2 and overflow logic stay in mac_result_requant.
// TESTING
//  1 mac_result=1000, bias=24, shift=4 -> out_data=64, out_valid in cycle T+3.
//  2 mac_result=100000, bias=0, shift=0 -> 127; mac_result=-100000 -> -128.
//  3 mac_result=-24, bias=0, shift=4 -> -1; mac_result=-25 -> -2 (round half up).
//  4 out_ready=0, five back-to-back mac_done -> fifo_count=4, overflow=1, drained outputs are
//    first four values in order.
//  5 FIFO full, push and pop in same cycle -> count stays 4, overflow stays 0; flush then -> count=0,
//    out_valid=0, overflow=0; rst pulse mid-burst -> all outputs 0 asynchronously.
//  6 mac_result=-50, shift=0 -> 0 with REQUANT_RELU_EN, -50 without.

Source files
------------

// File: rtl/vec_mac_pkg.sv
// Shared types and the saturation helper for the MAC result requantiser.
// Used by mac_result_requant and its testbench.
package vec_mac_pkg;

  localparam int ACC_W = 32;
  localparam int OUT_W = 8;
  // Two bits of headroom above the accumulator width. They hold the bias sum
  // plus the rounding constant without wrap.
  localparam int SUM_W = ACC_W + 2;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] qout_t;
  typedef logic signed [SUM_W-1:0] wide_t;

  localparam wide_t QMAX = (wide_t'(1) <<< (OUT_W - 1)) - wide_t'(1);
  localparam wide_t QMIN = -(wide_t'(1) <<< (OUT_W - 1));

  function automatic qout_t sat_to_out(input wide_t v);
    if (v > QMAX) begin
      return qout_t'(QMAX);
    end else if (v < QMIN) begin
      return qout_t'(QMIN);
    end else begin
      return qout_t'(v);
    end
  endfunction

endpackage

// File: rtl/requant_fifo.sv
// Synchronous FIFO for quantised results, with a flush that clears the pointers.
// rdata_o shows the head entry and reads 0 while the FIFO is empty.
module requant_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mac_result_requant.sv
// Requantises MAC results: bias add, rounding shift and saturation, then buffering in a FIFO.
// Define REQUANT_RELU_EN to clamp negative outputs to zero.
module mac_result_requant
  import vec_mac_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SHIFT_W    = $clog2(ACC_W),
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [ACC_W-1:0]   mac_result_i,
  input  logic               mac_done_i,
  input  logic [ACC_W-1:0]   bias_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               flush_i,
  output logic [OUT_W-1:0]   out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [CNT_W-1:0]   fifo_count_o,
  output logic               overflow_o
);

  logic [ACC_W:0]     sum1_q, sum1_d;
  logic [SHIFT_W-1:0] shift1_q;
  logic               v1_q, v2_q;
  qout_t              q2_q, q2_d;
  wide_t              ext2, rnd2, shifted2;
  logic               overflow_q;
  logic               fifo_full, fifo_empty, fifo_pop;

  assign sum1_d = {mac_result_i[ACC_W-1], mac_result_i} + {bias_i[ACC_W-1], bias_i};

  // Adding half an LSB before the floor shift rounds half up.
  always_comb begin
    ext2     = {sum1_q[ACC_W], sum1_q};
    rnd2     = '0;
    if (shift1_q != '0) rnd2 = wide_t'(1) << (shift1_q - SHIFT_W'(1));
    shifted2 = (ext2 + rnd2) >>> shift1_q;
    q2_d     = sat_to_out(shifted2);
`ifdef REQUANT_RELU_EN
    if (q2_d[OUT_W-1]) q2_d = '0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      sum1_q     <= '0;
      shift1_q   <= '0;
      q2_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      v1_q     <= mac_done_i & ~flush_i;
      v2_q     <= v1_q & ~flush_i;
      sum1_q   <= sum1_d;
      shift1_q <= shift_i;
      q2_q     <= q2_d;
      if (flush_i) begin
        overflow_q <= 1'b0;
      end else if (v2_q && fifo_full && !fifo_pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign fifo_pop    = out_ready_i & ~fifo_empty;
  assign out_valid_o = ~fifo_empty;
  assign overflow_o  = overflow_q;

  requant_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (v2_q),
    .pop_i   (out_ready_i),
    .wdata_i (q2_q),
    .rdata_o (out_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

endmodule

// File: tb/tb_mac_result_requant.sv
// Randomised and directed bench for mac_result_requant against an arithmetic reference model.
module tb_mac_result_requant;
  import vec_mac_pkg::*;

  localparam int DEPTH = 4;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [31:0]      mac_result_i = '0;
  logic             mac_done_i = 1'b0;
  logic [31:0]      bias_i = '0;
  logic [4:0]       shift_i = '0;
  logic             flush_i = 1'b0;
  logic [7:0]       out_data_o;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [2:0]       fifo_count_o;
  logic             overflow_o;

  int checks = 0;
  int errors = 0;

  typedef struct {int val; int due;} item_t;
  int    fifo_m[$];
  item_t sched[$];
  bit    ovf_m = 1'b0;
  int    edge_n = 0;

  mac_result_requant #(.FIFO_DEPTH(DEPTH), .SHIFT_W(5)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .mac_result_i (mac_result_i),
    .mac_done_i   (mac_done_i),
    .bias_i       (bias_i),
    .shift_i      (shift_i),
    .flush_i      (flush_i),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .fifo_count_o (fifo_count_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int quant(int m, int b, int s);
    longint v;
    v = longint'(m) + longint'(b);
    if (s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`ifdef REQUANT_RELU_EN
    if (v < 0) v = 0;
`endif
    return int'(v);
  endfunction

  // The model applies the clock edge that follows using the inputs driven right now.
  task automatic tick();
    int sz;
    bit pop;
    item_t it;
    if (flush_i) begin
      fifo_m.delete();
      sched.delete();
      ovf_m = 1'b0;
    end else begin
      sz  = fifo_m.size();
      pop = out_ready_i && (sz > 0);
      if (mac_done_i) begin
        it.val = quant(int'(mac_result_i), int'(bias_i), int'(shift_i));
        it.due = edge_n + 2;
        sched.push_back(it);
      end
      if (pop) void'(fifo_m.pop_front());
      if (sched.size() > 0 && sched[0].due == edge_n) begin
        it = sched.pop_front();
        if (sz < DEPTH || pop) fifo_m.push_back(it.val);
        else ovf_m = 1'b1;
      end
    end
    edge_n++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(int m, int b, int s);
    mac_done_i   = 1'b1;
    mac_result_i = m;
    bias_i       = b;
    shift_i      = 5'(s);
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    checks++;
    if (out_valid_o !== 1'b0 || out_data_o !== 8'd0 || fifo_count_o !== 3'd0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%0d count=%0d ovf=%b, required all 0",
               out_valid_o, out_data_o, fifo_count_o, overflow_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    int dm[6] = '{1000, 100000, -100000, -24, -25, -50};
    int db[6] = '{24, 0, 0, 0, 0, 0};
    int ds[6] = '{4, 0, 0, 4, 4, 0};
`ifdef REQUANT_RELU_EN
    int de[6] = '{64, 127, 0, 0, 0, 0};
`else
    int de[6] = '{64, 127, -128, -1, -2, -50};
`endif
    for (int i = 0; i < 6; i++) begin
      drive(dm[i], db[i], ds[i]);
      tick();
      mac_done_i = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        checks++;
        if (out_valid_o !== (c == 3)) begin
          errors++;
          $display("FAIL latency vec%0d cycle T+%0d: valid=%b required %b", i, c, out_valid_o, (c == 3));
        end
        if (c < 3) tick();
      end
      checks++;
      if (int'($signed(out_data_o)) !== de[i]) begin
        errors++;
        $display("FAIL value vec%0d: got %0d required %0d", i, $signed(out_data_o), de[i]);
      end
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      checks++;
      if (out_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL pop vec%0d: valid=%b required 0", i, out_valid_o);
      end
    end
  endtask

  task automatic test_overflow();
    int exp_v[5];
    do_flush();
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 200)) - 100,
            int'($urandom_range(0, 6)));
      exp_v[i] = quant(int'(mac_result_i), int'(bias_i), int'(shift_i));
      tick();
    end
    mac_done_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (fifo_count_o !== 3'd4 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow: count=%0d ovf=%b required count=4 ovf=1", fifo_count_o, overflow_o);
    end
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (int'($signed(out_data_o)) !== exp_v[i]) begin
        errors++;
        $display("FAIL drain order %0d: got %0d required %0d", i, $signed(out_data_o), exp_v[i]);
      end
      tick();
    end
    out_ready_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL after drain: valid=%b ovf=%b required valid=0 ovf=1", out_valid_o, overflow_o);
    end
  endtask

  task automatic test_full_push_pop();
    do_flush();
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(i * 16, 0, 4);
      tick();
    end
    mac_done_i = 1'b0;
    repeat (2) tick();
    drive(1600, 0, 4);
    tick();
    mac_done_i = 1'b0;
    tick();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    checks++;
    if (fifo_count_o !== 3'd4 || overflow_o !== 1'b0 || int'($signed(out_data_o)) !== fifo_m[0]) begin
      errors++;
      $display("FAIL full push+pop: count=%0d ovf=%b head=%0d required count=4 ovf=0 head=%0d",
               fifo_count_o, overflow_o, $signed(out_data_o), fifo_m[0]);
    end
    drive(-3000, 7, 2);
    tick();
    mac_done_i = 1'b0;
    repeat (2) tick();
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL full drop: ovf=%b required 1", overflow_o);
    end
    // flush must win over a same-cycle mac_done and pop
    drive(500, 0, 0);
    out_ready_i = 1'b1;
    do_flush();
    mac_done_i  = 1'b0;
    out_ready_i = 1'b0;
    checks++;
    if (fifo_count_o !== 3'd0 || out_valid_o !== 1'b0 || overflow_o !== 1'b0 || out_data_o !== 8'd0) begin
      errors++;
      $display("FAIL flush: count=%0d valid=%b ovf=%b data=%0d required all 0",
               fifo_count_o, out_valid_o, overflow_o, out_data_o);
    end
    repeat (4) tick();
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush discard: valid=%b required 0", out_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(int'($urandom_range(0, 2000)), 0, 3);
      tick();
    end
    checks++;
    if (out_valid_o !== 1'b1 || int'(fifo_count_o) !== fifo_m.size()) begin
      errors++;
      $display("FAIL pre-reset: valid=%b count=%0d required valid=1 count=%0d",
               out_valid_o, fifo_count_o, fifo_m.size());
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || out_data_o !== 8'd0 || fifo_count_o !== 3'd0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL async reset: valid=%b data=%0d count=%0d ovf=%b required all 0",
               out_valid_o, out_data_o, fifo_count_o, overflow_o);
    end
    fifo_m.delete();
    sched.delete();
    ovf_m = 1'b0;
    mac_done_i = 1'b0;
    #2 rst_ni = 1'b1;
    repeat (4) tick();
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL in-flight discard: valid=%b required 0", out_valid_o);
    end
  endtask

  task automatic test_random();
    int m;
    int exp_d;
    for (int n = 0; n < 400; n++) begin
      mac_done_i  = ($urandom_range(0, 3) != 0);
      m = ($urandom_range(0, 3) == 0) ? int'($urandom()) : int'($urandom_range(0, 20000)) - 10000;
      mac_result_i = m;
      bias_i      = ($urandom_range(0, 7) == 0) ? $urandom() : 32'(int'($urandom_range(0, 1000)) - 500);
      shift_i     = 5'($urandom_range(0, 31));
      out_ready_i = ($urandom_range(0, 2) != 0);
      flush_i     = ($urandom_range(0, 40) == 0);
      tick();
      exp_d = (fifo_m.size() > 0) ? fifo_m[0] : 0;
      checks++;
      if (out_valid_o !== (fifo_m.size() > 0) || int'(fifo_count_o) !== fifo_m.size() ||
          overflow_o !== ovf_m || int'($signed(out_data_o)) !== exp_d) begin
        errors++;
        $display("FAIL random cycle %0d: valid=%b count=%0d ovf=%b data=%0d required valid=%b count=%0d ovf=%b data=%0d",
                 n, out_valid_o, fifo_count_o, overflow_o, $signed(out_data_o),
                 (fifo_m.size() > 0), fifo_m.size(), ovf_m, exp_d);
      end
    end
    mac_done_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
